bit2real_serializer: RTL and testbench

- Word-to-bitstream scheduler for the bit2real primitive.
- Accepts parallel words over a valid/ready handshake and serialises them one bit at a time, with a programmable bit period in clock cycles.
- Drives an internal bit2real instance, so downstream real-valued models (DAC/driver/channel stimulus) see vh/vl levels.
- Sits between digital pattern sources (PRBS, test vectors) and analog-behavioural loads.

---
 rtl/bit2real_ser_pkg.sv | 9 +
 rtl/bit2real.sv | 12 +
 rtl/bit2real_serializer.sv | 92 +++++++++
 tb/tb_bit2real_serializer.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/bit2real_ser_pkg.sv
// bit2real_ser_pkg: shared state encoding and sizing helpers for the bit2real serializer
package bit2real_ser_pkg;
  typedef enum logic {ST_IDLE = 1'b0, ST_SHIFT = 1'b1} state_e;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_DIVW  = 8;
  function automatic int bidx_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction
endpackage

// File: rtl/bit2real.sv
// bit2real: maps a logic bit to complementary real levels (din -> out/outb = vh/vl)
module bit2real #(
  parameter real vh = 1.0,
  parameter real vl = 0.0
) (
  input  logic din,
  output real  out,
  output real  outb
);
  assign out  = din ? vh : vl;
  assign outb = din ? vl : vh;
endmodule

// File: rtl/bit2real_serializer.sv
// bit2real_serializer: valid/ready word-to-bitstream scheduler with programmable bit period, driving bit2real (clk, rstn, en, div, msb_first, in_valid/in_data/in_ready -> bit_out, busy, done, out, outb)
module bit2real_serializer
  import bit2real_ser_pkg::*;
#(
  parameter int   WIDTH    = DEF_WIDTH,
  parameter int   DIVW     = DEF_DIVW,
  parameter real  vh       = 1.0,
  parameter real  vl       = 0.0,
  parameter logic IDLE_BIT = 1'b0
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            en,
  input  logic [DIVW-1:0] div,
  input  logic            msb_first,
  input  logic            in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic            in_ready,
  output logic            bit_out,
  output logic            busy,
  output logic            done,
  output real             out,
  output real             outb
);
  localparam int BW = bidx_width(WIDTH);
  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [DIVW-1:0]  div_q, div_d, cnt_q, cnt_d;
  logic [BW-1:0]    bidx_q, bidx_d;
  logic             ord_q, ord_d, done_q, done_d;
  logic             wrap, last, fire;
  assign wrap     = (state_q == ST_SHIFT) && (cnt_q == div_q);
  assign last     = wrap && (bidx_q == BW'(WIDTH - 1));
  assign in_ready = en && ((state_q == ST_IDLE) || last);
  assign fire     = in_valid && in_ready;
  // The output bit is always the end of the shift register facing the chosen order.
  assign bit_out  = (state_q == ST_SHIFT) ? (ord_q ? shreg_q[WIDTH-1] : shreg_q[0]) : IDLE_BIT;
  assign busy     = (state_q == ST_SHIFT);
  assign done     = done_q;
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    div_d   = div_q;
    ord_d   = ord_q;
    cnt_d   = cnt_q;
    bidx_d  = bidx_q;
    done_d  = en && last;
    if (!en) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      bidx_d  = '0;
    end else if (fire) begin
      state_d = ST_SHIFT;
      shreg_d = in_data;
      div_d   = div;
      ord_d   = msb_first;
      cnt_d   = '0;
      bidx_d  = '0;
    end else if (wrap) begin
      cnt_d   = '0;
      bidx_d  = last ? '0 : bidx_q + BW'(1);
      shreg_d = ord_q ? (shreg_q << 1) : (shreg_q >> 1);
      state_d = last ? ST_IDLE : ST_SHIFT;
    end else if (state_q == ST_SHIFT) begin
      cnt_d   = cnt_q + DIVW'(1);
    end
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      div_q   <= '0;
      ord_q   <= 1'b0;
      cnt_q   <= '0;
      bidx_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      div_q   <= div_d;
      ord_q   <= ord_d;
      cnt_q   <= cnt_d;
      bidx_q  <= bidx_d;
      done_q  <= done_d;
    end
  end
  bit2real #(.vh(vh), .vl(vl)) u_b2r (
    .din  (bit_out),
    .out  (out),
    .outb (outb)
  );
endmodule

// File: tb/tb_bit2real_serializer.sv
// tb_bit2real_serializer: directed self-checking bench for bit2real_serializer
module tb_bit2real_serializer;
  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       en = 1'b0;
  logic [7:0] div = '0;
  logic       msb_first = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_ready, bit_out, busy, done;
  real        out, outb;
  int         checks = 0;
  int         errors = 0;

  bit2real_serializer #(.WIDTH(8), .DIVW(8), .vh(1.0), .vl(0.0), .IDLE_BIT(1'b0)) dut (
    .clk(clk), .rstn(rstn), .en(en), .div(div), .msb_first(msb_first),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .bit_out(bit_out), .busy(busy), .done(done), .out(out), .outb(outb)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #3;
    checks++; if (bit_out !== 1'b0) begin errors++; $display("FAIL reset_bit got %b want 0", bit_out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", in_ready); end
    checks++; if (out != 0.0 || outb != 1.0) begin errors++; $display("FAIL reset_levels got %f/%f want 0.0/1.0", out, outb); end
    step(); rstn = 1'b1; step();
  endtask

  task automatic test_basic_a5();
    logic [7:0] w;
    logic e;
    w = 8'hA5;
    en = 1'b1; div = 8'd0; msb_first = 1'b1; in_data = w; in_valid = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL a5_ready_idle got %b want 1", in_ready); end
    step(); in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      e = w[7-i];
      checks++; if (bit_out !== e) begin errors++; $display("FAIL a5_bit%0d got %b want %b", i, bit_out, e); end
      checks++; if (out != (e ? 1.0 : 0.0)) begin errors++; $display("FAIL a5_out%0d got %f want %f", i, out, e ? 1.0 : 0.0); end
      checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL a5_busy%0d got busy=%b done=%b want 1/0", i, busy, done); end
      step();
    end
    checks++; if (done !== 1'b1 || busy !== 1'b0 || bit_out !== 1'b0) begin errors++; $display("FAIL a5_end got done=%b busy=%b bit=%b want 1/0/0", done, busy, bit_out); end
    step();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL a5_done_single got %b want 0", done); end
  endtask

  task automatic test_div3_lsb();
    div = 8'd3; msb_first = 1'b0; in_data = 8'h01; in_valid = 1'b1;
    step(); in_valid = 1'b0;
    for (int c = 0; c < 32; c++) begin
      checks++; if (bit_out !== (c < 4)) begin errors++; $display("FAIL d3_bit_c%0d got %b want %b", c, bit_out, c < 4); end
      checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL d3_busy_c%0d got busy=%b done=%b want 1/0", c, busy, done); end
      checks++; if (in_ready !== (c == 31)) begin errors++; $display("FAIL d3_ready_c%0d got %b want %b", c, in_ready, c == 31); end
      step();
    end
    checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL d3_end got done=%b busy=%b want 1/0", done, busy); end
    step();
  endtask

  task automatic test_back_to_back();
    div = 8'd1; msb_first = 1'b1; in_data = 8'hFF; in_valid = 1'b1;
    step(); in_data = 8'h00;
    for (int c = 0; c < 32; c++) begin
      if (c == 16) in_valid = 1'b0;
      checks++; if (bit_out !== (c < 16)) begin errors++; $display("FAIL b2b_bit_c%0d got %b want %b", c, bit_out, c < 16); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy_c%0d got %b want 1", c, busy); end
      checks++; if (done !== (c == 16)) begin errors++; $display("FAIL b2b_done_c%0d got %b want %b", c, done, c == 16); end
      step();
    end
    checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL b2b_end got done=%b busy=%b want 1/0", done, busy); end
    step();
  endtask

  task automatic test_abort();
    logic [7:0] w;
    w = 8'hF0;
    div = 8'd0; msb_first = 1'b1; in_data = w; in_valid = 1'b1;
    step(); in_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      checks++; if (bit_out !== w[7-c]) begin errors++; $display("FAIL ab_bit_c%0d got %b want %b", c, bit_out, w[7-c]); end
      if (c == 4) en = 1'b0;
      step();
    end
    checks++; if (bit_out !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL ab_idle got bit=%b busy=%b done=%b rdy=%b want 0/0/0/0", bit_out, busy, done, in_ready); end
    step();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL ab_nodone got %b want 0", done); end
    en = 1'b1; #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL ab_ready_reen got %b want 1", in_ready); end
    w = 8'h80; in_data = w; in_valid = 1'b1;
    step(); in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++; if (bit_out !== w[7-i]) begin errors++; $display("FAIL ab80_bit%0d got %b want %b", i, bit_out, w[7-i]); end
      step();
    end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL ab80_done got %b want 1", done); end
    step();
  endtask

  task automatic test_async_reset();
    div = 8'd0; msb_first = 1'b1; in_data = 8'hFF; in_valid = 1'b1;
    step(); in_valid = 1'b0; step();
    checks++; if (bit_out !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL rst_pre got bit=%b busy=%b want 1/1", bit_out, busy); end
    #2 rstn = 1'b0; #1;
    checks++; if (bit_out !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rst_async got bit=%b busy=%b done=%b want 0/0/0", bit_out, busy, done); end
    checks++; if (out != 0.0 || outb != 1.0) begin errors++; $display("FAIL rst_levels got %f/%f want 0.0/1.0", out, outb); end
    step(); rstn = 1'b1; step();
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rst_post got busy=%b done=%b want 0/0", busy, done); end
  endtask

  task automatic test_div_change();
    logic [7:0] w;
    w = 8'hAA;
    div = 8'd1; msb_first = 1'b1; in_data = w; in_valid = 1'b1;
    step(); in_valid = 1'b0; div = 8'd5; msb_first = 1'b0;
    for (int c = 0; c < 16; c++) begin
      checks++; if (bit_out !== w[7 - c/2]) begin errors++; $display("FAIL dc_bit_c%0d got %b want %b", c, bit_out, w[7 - c/2]); end
      step();
    end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL dc_done1 got %b want 1", done); end
    msb_first = 1'b1; in_data = 8'h80; in_valid = 1'b1;
    step(); in_valid = 1'b0;
    for (int c = 0; c < 48; c++) begin
      checks++; if (bit_out !== (c < 6) || busy !== 1'b1) begin errors++; $display("FAIL dc6_c%0d got bit=%b busy=%b want %b/1", c, bit_out, busy, c < 6); end
      step();
    end
    checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL dc6_end got done=%b busy=%b want 1/0", done, busy); end
  endtask

  initial begin
    test_reset();
    test_basic_a5();
    test_div3_lsb();
    test_back_to_back();
    test_abort();
    test_async_reset();
    test_div_change();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
